wall_probe_arbiter: RTL and testbench
=====================================

// Module: wall_probe_arbiter
// PURPOSE
//  Shares the single-port wall-map read port between movers (pacman + ghosts). Each mover asks for
//  the wall status of the 4 neighbours of its current tile. The block grants round-robin and runs 4
//  serialized reads (1-cycle latency). It returns a 4-bit blocked mask indexed by direction code
//  (`RIGHT/`LEFT/`UP/`DOWN), which replaces per-mover combinational wall_mask lookups.
// PARAMETERS
//  N_REQ    5   number of requesters (0 = pacman, 1..4 = ghosts)
//  START_X  0   leftmost legal tile column; END_X 39 rightmost legal tile column
//  START_Y  0   top legal tile row;         END_Y 29 bottom legal tile row
// PORTS
//  clk          in   1        system clock
//  resetN       in   1        synchronous, active-low reset
//  req          in   N_REQ    per-requester probe request, level, held until ack
//  req_tile_x   in   N_REQx7  per-requester tile column, stable while req=1
//  req_tile_y   in   N_REQx7  per-requester tile row, stable while req=1
//  ack          out  N_REQ    one-hot, 1-cycle pulse: probe_mask valid for that requester
//  probe_mask   out  4        bit[d]=1 -> neighbour in direction d is a wall; held until next ack
//  mem_rd       out  1        wall-map read strobe
//  mem_x        out  7        wall-map read column
//  mem_y        out  7        wall-map read row
//  mem_rdata    in   1        wall bit; valid the cycle after mem_rd
//  busy         out  1        1 in every state except IDLE
// BEHAVIOUR
//  Reset (resetN=0 at a clk edge): state=IDLE, ack=0, probe_mask=0, mem_rd=0, mem_x=mem_y=0, rr_ptr=0.
//   Reset mid-probe aborts the probe. No ack is issued for it.
//  States: IDLE -> PROBE (4 cycles) -> WAIT (1) -> DONE (1) -> IDLE.
//  IDLE (cycle T): if any req, pick the first set bit scanning rr_ptr, rr_ptr+1, ... (mod N_REQ).
//   Latch gnt index, tile_x and tile_y. Go to PROBE.
//  PROBE (T+1..T+4): mem_rd=1. One neighbour per cycle, in direction-code order 0,1,2,3:
//   RIGHT=(x+1,y)  LEFT=(x-1,y)  UP=(x,y-1)  DOWN=(x,y+1).
//   Neighbour arithmetic is 8-bit signed, so x-1 at x=0 gives -1 (no wrap to 127).
//   If the neighbour lies outside [START_X..END_X]x[START_Y..END_Y]:
//    mem_x/mem_y = the latched tile, and that mask bit is forced 0. The edge is not blocked (tunnel).
//    The read strobe still pulses, so timing stays fixed.
//  Capture: mem_rdata sampled at T+2..T+5 into an internal mask bit 0..3.
//  WAIT (T+5): last capture only, mem_rd=0.
//  DONE (T+6): probe_mask <= captured mask; ack[gnt]=1 this cycle only; rr_ptr <= gnt+1 (wrap at N_REQ).
//   Next state is IDLE.
//  Fixed latency: 6 cycles from grant to ack. One probe per 7 cycles, so it is starved-free:
//   a waiting requester is served within N_REQ probes.
//  Requester drops req mid-probe: the probe still completes and ack still pulses. The requester ignores it.
//  Requester raises req again on its ack cycle: the next IDLE sees it. Round-robin puts others first.
//  Tile changes while req=1: undefined result; the requester must not do this.
//  Simultaneous reqs: only the round-robin winner is granted. The others wait with no lost requests.
//  mem_x/mem_y hold their last value when mem_rd=0.
// TESTING
//  1: Only req[0] at tile (19,16); map has walls at (20,16) and (19,15).
//     -> ack[0] exactly 6 cycles after grant; probe_mask[`RIGHT]=1, [`UP]=1, others 0.
//  2: req[0] at tile (0,14), tunnel row, all-wall map.
//     -> probe_mask[`LEFT]=0; other bits 1; mem_rd still 4 consecutive cycles.
//  3: req=5'b11111 held continuously.
//     -> ack order 0,1,2,3,4,0,...; each ack is exactly 7 cycles after the previous one.
//  4: rr_ptr=3 after serving 2; then req=5'b00101.
//     -> requester 0 is granted before 2.
//  5: resetN=0 at cycle T+3 of a probe.
//     -> next cycle busy=0, mem_rd=0, no ack ever for that probe; a fresh req is granted normally.
//  6: req[1] dropped at T+2.
//     -> ack[1] still pulses at T+6; the next grant goes to another pending requester.

Source files
------------

// File: rtl/wall_probe_if.sv
// Probe request/ack bus between movers and the arbiter, plus the wall-map read port.
// The arbiter uses the slave modport; movers and the wall map sit on the master side.
interface wall_probe_if #(
    parameter int N_REQ = 5
);
    logic [N_REQ-1:0]      req;
    logic [N_REQ-1:0][6:0] req_tile_x;
    logic [N_REQ-1:0][6:0] req_tile_y;
    logic [N_REQ-1:0]      ack;
    logic [3:0]            probe_mask;
    logic                  mem_rd;
    logic [6:0]            mem_x;
    logic [6:0]            mem_y;
    logic                  mem_rdata;
    logic                  busy;

    modport master (
        output req, req_tile_x, req_tile_y, mem_rdata,
        input  ack, probe_mask, mem_rd, mem_x, mem_y, busy
    );

    modport slave (
        input  req, req_tile_x, req_tile_y, mem_rdata,
        output ack, probe_mask, mem_rd, mem_x, mem_y, busy
    );
endinterface

// File: rtl/wall_probe_arbiter.sv
// Round-robin arbiter sharing the wall-map read port: each grant issues four neighbour
// reads (RIGHT, LEFT, UP, DOWN) and returns a blocked mask with a one-cycle ack.
module wall_probe_arbiter #(
    parameter int N_REQ   = 5,
    parameter int START_X = 0,
    parameter int END_X   = 39,
    parameter int START_Y = 0,
    parameter int END_Y   = 29
) (
    input  logic         clk,
    input  logic         resetN,
    wall_probe_if.slave  bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic signed [7:0] SX = 8'(START_X);
    localparam logic signed [7:0] EX = 8'(END_X);
    localparam logic signed [7:0] SY = 8'(START_Y);
    localparam logic signed [7:0] EY = 8'(END_Y);

    typedef enum logic [1:0] {IDLE, PROBE, WAIT, DONE} state_t;

    state_t            state, state_n;
    logic [1:0]        dir, dir_n;
    logic [IDX_W-1:0]  rr_ptr, gnt, sel;
    logic              found;
    logic [6:0]        tile_x, tile_y, tile_x_n, tile_y_n;
    logic [3:0]        cap, oob, mask_q;
    logic signed [7:0] nx, ny;
    logic              nb_oob;
    logic [6:0]        rd_x, rd_y;
    logic [N_REQ-1:0]  ack_q;
    logic              rd_q;
    logic [6:0]        mx_q, my_q;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            int unsigned k;
            k = (32'(rr_ptr) + i) % N_REQ;
            if (!found && bus.req[k]) begin
                found = 1'b1;
                sel   = IDX_W'(k);
            end
        end
    end

    always_comb begin
        state_n  = state;
        dir_n    = dir;
        tile_x_n = tile_x;
        tile_y_n = tile_y;
        case (state)
            IDLE: if (found) begin
                state_n  = PROBE;
                dir_n    = 2'd0;
                tile_x_n = bus.req_tile_x[sel];
                tile_y_n = bus.req_tile_y[sel];
            end
            PROBE: if (dir == 2'd3) state_n = WAIT;
                   else             dir_n   = dir + 2'd1;
            WAIT:    state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Address for the read issued in the upcoming cycle, derived from next-state values so
    // the registered strobe/address line up with the PROBE cycle they belong to.
    always_comb begin
        nx = $signed({1'b0, tile_x_n});
        ny = $signed({1'b0, tile_y_n});
        case (dir_n)
            2'd0: nx = nx + 8'sd1;
            2'd1: nx = nx - 8'sd1;
            2'd2: ny = ny - 8'sd1;
            2'd3: ny = ny + 8'sd1;
        endcase
        nb_oob = (nx < SX) || (nx > EX) || (ny < SY) || (ny > EY);
        rd_x   = nb_oob ? tile_x_n : nx[6:0];
        rd_y   = nb_oob ? tile_y_n : ny[6:0];
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state  <= IDLE;
            dir    <= 2'd0;
            rr_ptr <= '0;
            gnt    <= '0;
            tile_x <= '0;
            tile_y <= '0;
            cap    <= '0;
            oob    <= '0;
            mask_q <= '0;
            ack_q  <= '0;
            rd_q   <= 1'b0;
            mx_q   <= '0;
            my_q   <= '0;
        end else begin
            state  <= state_n;
            dir    <= dir_n;
            tile_x <= tile_x_n;
            tile_y <= tile_y_n;
            ack_q  <= '0;
            rd_q   <= (state_n == PROBE);
            if (state_n == PROBE) begin
                mx_q       <= rd_x;
                my_q       <= rd_y;
                oob[dir_n] <= nb_oob;
            end
            if (state == IDLE && found)
                gnt <= sel;
            // Read data trails the strobe by one cycle, so capture lags the direction counter.
            if (state == PROBE && dir != 2'd0)
                cap[dir - 2'd1] <= bus.mem_rdata;
            if (state == WAIT) begin
                mask_q     <= {bus.mem_rdata, cap[2:0]} & ~oob;
                ack_q[gnt] <= 1'b1;
                rr_ptr     <= (gnt == IDX_W'(N_REQ - 1)) ? '0 : gnt + 1'b1;
            end
        end
    end

    assign bus.ack        = ack_q;
    assign bus.probe_mask = mask_q;
    assign bus.mem_rd     = rd_q;
    assign bus.mem_x      = mx_q;
    assign bus.mem_y      = my_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_wall_probe_arbiter.sv
// Directed bench for wall_probe_arbiter: wall-map model, event logs and per-scenario checks.
module tb_wall_probe_arbiter;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    wall_probe_if #(.N_REQ(5)) bus();

    wall_probe_arbiter #(.N_REQ(5), .START_X(0), .END_X(39), .START_Y(0), .END_Y(29)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit walls [0:127][0:127];
    always @(posedge clk) bus.mem_rdata <= bus.mem_rd ? walls[bus.mem_x][bus.mem_y] : 1'b0;

    int       ack_cyc[$];
    int       ack_idx[$];
    logic [3:0] ack_mask[$];
    int       rd_cyc[$];
    int       rd_x[$];
    int       rd_y[$];
    int       gnt_cyc[$];
    int       onehot_err = 0;
    logic     prev_busy = 1'b0;

    always @(negedge clk) begin
        int idx;
        if (bus.ack !== 5'b0) begin
            idx = -1;
            for (int i = 0; i < 5; i++) if (bus.ack[i] === 1'b1) idx = i;
            if ($countones(bus.ack) != 1) onehot_err++;
            ack_cyc.push_back(cyc);
            ack_idx.push_back(idx);
            ack_mask.push_back(bus.probe_mask);
        end
        if (bus.mem_rd === 1'b1) begin
            rd_cyc.push_back(cyc);
            rd_x.push_back(int'(bus.mem_x));
            rd_y.push_back(int'(bus.mem_y));
        end
        if (bus.busy === 1'b1 && prev_busy !== 1'b1) gnt_cyc.push_back(cyc - 1);
        prev_busy = bus.busy;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        ack_cyc.delete(); ack_idx.delete(); ack_mask.delete();
        rd_cyc.delete(); rd_x.delete(); rd_y.delete(); gnt_cyc.delete();
    endtask

    task automatic set_walls(input bit v);
        for (int x = 0; x < 128; x++)
            for (int y = 0; y < 128; y++) walls[x][y] = v;
    endtask

    task automatic do_reset();
        bus.req = '0;
        resetN = 1'b0;
        tick(2);
        resetN = 1'b1;
        tick(1);
        clear_logs();
    endtask

    task automatic wait_acks(input int n, input int budget);
        int k = 0;
        while (ack_idx.size() < n && k < budget) begin
            tick(1);
            k++;
        end
    endtask

    task automatic test_reset();
        bus.req = '0;
        resetN = 1'b0;
        tick(2);
        checks++; if (bus.ack !== 5'b0) begin errors++; $display("FAIL reset_ack got %b want 00000", bus.ack); end
        checks++; if (bus.probe_mask !== 4'b0) begin errors++; $display("FAIL reset_mask got %b want 0000", bus.probe_mask); end
        checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got %b want 0", bus.mem_rd); end
        checks++; if (bus.mem_x !== 7'd0 || bus.mem_y !== 7'd0) begin errors++; $display("FAIL reset_mem_xy got %0d,%0d want 0,0", bus.mem_x, bus.mem_y); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        resetN = 1'b1;
        tick(1);
        clear_logs();
    endtask

    task automatic test_single_probe();
        int ex[4] = '{20, 18, 19, 19};
        int ey[4] = '{16, 16, 15, 17};
        do_reset();
        set_walls(1'b0);
        walls[20][16] = 1'b1;
        walls[19][15] = 1'b1;
        bus.req_tile_x[0] = 7'd19;
        bus.req_tile_y[0] = 7'd16;
        bus.req = 5'b00001;
        wait_acks(1, 20);
        bus.req = '0;
        checks++;
        if (ack_idx.size() != 1 || gnt_cyc.size() < 1) begin
            errors++; $display("FAIL single_ack_count got %0d want 1", ack_idx.size());
        end else begin
            checks++; if (ack_idx[0] != 0) begin errors++; $display("FAIL single_ack_idx got %0d want 0", ack_idx[0]); end
            checks++; if (ack_cyc[0] - gnt_cyc[0] != 6) begin errors++; $display("FAIL single_latency got %0d want 6", ack_cyc[0] - gnt_cyc[0]); end
            checks++; if (ack_mask[0] !== 4'b0101) begin errors++; $display("FAIL single_mask got %b want 0101", ack_mask[0]); end
        end
        checks++;
        if (rd_x.size() != 4) begin
            errors++; $display("FAIL single_read_count got %0d want 4", rd_x.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd_x[i] != ex[i] || rd_y[i] != ey[i]) begin
                    errors++; $display("FAIL single_read%0d got %0d,%0d want %0d,%0d", i, rd_x[i], rd_y[i], ex[i], ey[i]);
                end
            end
        end
        tick(3);
        checks++; if (bus.probe_mask !== 4'b0101) begin errors++; $display("FAIL single_mask_hold got %b want 0101", bus.probe_mask); end
        checks++; if (bus.mem_rd !== 1'b0 || bus.mem_x !== 7'd19 || bus.mem_y !== 7'd17) begin
            errors++; $display("FAIL single_addr_hold got rd=%b %0d,%0d want rd=0 19,17", bus.mem_rd, bus.mem_x, bus.mem_y);
        end
    endtask

    task automatic test_tunnel_edge();
        do_reset();
        set_walls(1'b1);
        bus.req_tile_x[0] = 7'd0;
        bus.req_tile_y[0] = 7'd14;
        bus.req = 5'b00001;
        wait_acks(1, 20);
        bus.req = '0;
        checks++;
        if (ack_mask.size() != 1) begin
            errors++; $display("FAIL tunnel_ack_count got %0d want 1", ack_mask.size());
        end else begin
            checks++; if (ack_mask[0] !== 4'b1101) begin errors++; $display("FAIL tunnel_mask got %b want 1101", ack_mask[0]); end
        end
        checks++;
        if (rd_cyc.size() != 4) begin
            errors++; $display("FAIL tunnel_read_count got %0d want 4", rd_cyc.size());
        end else begin
            checks++; if (rd_cyc[3] - rd_cyc[0] != 3) begin errors++; $display("FAIL tunnel_read_span got %0d want 3", rd_cyc[3] - rd_cyc[0]); end
            checks++; if (rd_x[1] != 0 || rd_y[1] != 14) begin errors++; $display("FAIL tunnel_left_addr got %0d,%0d want 0,14", rd_x[1], rd_y[1]); end
        end
        tick(2);
    endtask

    task automatic test_all_requests();
        int exp_order[7] = '{0, 1, 2, 3, 4, 0, 1};
        do_reset();
        set_walls(1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.req_tile_x[i] = 7'(10 + i);
            bus.req_tile_y[i] = 7'd10;
        end
        walls[13][11] = 1'b1;
        bus.req = 5'b11111;
        wait_acks(7, 80);
        bus.req = '0;
        checks++;
        if (ack_idx.size() != 7) begin
            errors++; $display("FAIL rr_ack_count got %0d want 7", ack_idx.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (ack_idx[i] != exp_order[i]) begin errors++; $display("FAIL rr_order%0d got %0d want %0d", i, ack_idx[i], exp_order[i]); end
            end
            for (int i = 1; i < 7; i++) begin
                checks++;
                if (ack_cyc[i] - ack_cyc[i-1] != 7) begin errors++; $display("FAIL rr_spacing%0d got %0d want 7", i, ack_cyc[i] - ack_cyc[i-1]); end
            end
            checks++; if (ack_mask[3] !== 4'b1000) begin errors++; $display("FAIL rr_mask3 got %b want 1000", ack_mask[3]); end
            checks++; if (ack_mask[2] !== 4'b0000) begin errors++; $display("FAIL rr_mask2 got %b want 0000", ack_mask[2]); end
        end
        checks++; if (onehot_err != 0) begin errors++; $display("FAIL ack_onehot got %0d bad acks want 0", onehot_err); end
        tick(2);
    endtask

    task automatic test_rr_pointer();
        do_reset();
        set_walls(1'b0);
        bus.req_tile_x[0] = 7'd5;  bus.req_tile_y[0] = 7'd5;
        bus.req_tile_x[2] = 7'd7;  bus.req_tile_y[2] = 7'd7;
        bus.req = 5'b00100;
        wait_acks(1, 20);
        bus.req = '0;
        tick(1);
        clear_logs();
        bus.req = 5'b00101;
        wait_acks(1, 20);
        if (ack_idx.size() >= 1 && ack_idx[0] >= 0) bus.req[ack_idx[0]] = 1'b0;
        wait_acks(2, 20);
        bus.req = '0;
        checks++;
        if (ack_idx.size() != 2) begin
            errors++; $display("FAIL rrptr_ack_count got %0d want 2", ack_idx.size());
        end else begin
            checks++; if (ack_idx[0] != 0) begin errors++; $display("FAIL rrptr_first got %0d want 0", ack_idx[0]); end
            checks++; if (ack_idx[1] != 2) begin errors++; $display("FAIL rrptr_second got %0d want 2", ack_idx[1]); end
        end
        tick(2);
    endtask

    task automatic test_reset_mid_probe();
        int k = 0;
        do_reset();
        set_walls(1'b0);
        bus.req_tile_x[0] = 7'd19; bus.req_tile_y[0] = 7'd16;
        bus.req = 5'b00001;
        while (gnt_cyc.size() < 1 && k < 20) begin tick(1); k++; end
        checks++;
        if (gnt_cyc.size() < 1) begin
            errors++; $display("FAIL midreset_grant got none want 1");
        end else begin
            tick(2);
            resetN = 1'b0;
            bus.req = '0;
            tick(1);
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", bus.busy); end
            checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL midreset_mem_rd got %b want 0", bus.mem_rd); end
            resetN = 1'b1;
            tick(12);
            checks++; if (ack_idx.size() != 0) begin errors++; $display("FAIL midreset_no_ack got %0d acks want 0", ack_idx.size()); end
        end
        clear_logs();
        bus.req_tile_x[1] = 7'd5; bus.req_tile_y[1] = 7'd5;
        bus.req = 5'b00010;
        wait_acks(1, 20);
        bus.req = '0;
        checks++;
        if (ack_idx.size() != 1 || gnt_cyc.size() < 1) begin
            errors++; $display("FAIL midreset_fresh_count got %0d want 1", ack_idx.size());
        end else begin
            checks++; if (ack_idx[0] != 1) begin errors++; $display("FAIL midreset_fresh_idx got %0d want 1", ack_idx[0]); end
            checks++; if (ack_cyc[0] - gnt_cyc[0] != 6) begin errors++; $display("FAIL midreset_fresh_latency got %0d want 6", ack_cyc[0] - gnt_cyc[0]); end
        end
        tick(2);
    endtask

    task automatic test_drop_request();
        int k = 0;
        do_reset();
        set_walls(1'b0);
        bus.req_tile_x[1] = 7'd8; bus.req_tile_y[1] = 7'd8;
        bus.req_tile_x[3] = 7'd9; bus.req_tile_y[3] = 7'd9;
        bus.req = 5'b01010;
        while (gnt_cyc.size() < 1 && k < 20) begin tick(1); k++; end
        tick(1);
        bus.req[1] = 1'b0;
        wait_acks(2, 30);
        bus.req = '0;
        checks++;
        if (ack_idx.size() != 2 || gnt_cyc.size() < 1) begin
            errors++; $display("FAIL drop_ack_count got %0d want 2", ack_idx.size());
        end else begin
            checks++; if (ack_idx[0] != 1) begin errors++; $display("FAIL drop_first got %0d want 1", ack_idx[0]); end
            checks++; if (ack_cyc[0] - gnt_cyc[0] != 6) begin errors++; $display("FAIL drop_latency got %0d want 6", ack_cyc[0] - gnt_cyc[0]); end
            checks++; if (ack_idx[1] != 3) begin errors++; $display("FAIL drop_next got %0d want 3", ack_idx[1]); end
        end
        tick(2);
    endtask

    initial begin
        bus.req = '0;
        bus.req_tile_x = '0;
        bus.req_tile_y = '0;
        set_walls(1'b0);
        test_reset();
        test_single_probe();
        test_reset();
        test_tunnel_edge();
        test_all_requests();
        test_rr_pointer();
        test_reset_mid_probe();
        test_drop_request();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
